// File: rtl/bcd_digit_accumulator_if.sv
// Digit-in / result-out handshake bundle for bcd_digit_accumulator.
// The slave modport is the accumulator's view; master is the environment's view.
interface bcd_digit_accumulator_if #(
  parameter int OUT_W = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_value;
  logic             out_err;

  modport slave (
    input  in_valid,
    input  in_digit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_value,
    output out_err
  );

  modport master (
    output in_valid,
    output in_digit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_value,
    input  out_err
  );
endinterface

// File: rtl/bcd_digit_accumulator.sv
// Serial BCD-to-binary accumulator: NUM_DIGITS digits, MSD first, one result per word.
// Optional macro BCD_ACC_EXCESS3_IN_EN makes in_digit an excess-3 code decoded internally.
module bcd_digit_accumulator #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_digit_accumulator_if.slave   bus
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_value_q, out_value_d;
  logic             out_err_q, out_err_d;

  logic [3:0]       digit_val;
  logic             digit_bad;
  logic [OUT_W-1:0] acc_mac;
  logic             in_fire;
  logic             out_fire;

`ifdef BCD_ACC_EXCESS3_IN_EN
  // Excess-3: codes 3..12 map to 0..9, everything else is illegal.
  always_comb begin
    digit_bad = (bus.in_digit < 4'd3) || (bus.in_digit > 4'd12);
    digit_val = digit_bad ? 4'd0 : (bus.in_digit - 4'd3);
  end
`else
  always_comb begin
    digit_bad = (bus.in_digit > 4'd9);
    digit_val = digit_bad ? 4'd0 : bus.in_digit;
  end
`endif

  // acc*10 + d as shift-add; wraps silently at OUT_W, which the width rule makes unreachable.
  assign acc_mac = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, digit_val};

  assign in_fire  = bus.in_valid  && (state_q == ST_ACCUM);
  assign out_fire = bus.out_ready && (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_fire) begin
          acc_d = acc_mac;
          err_d = err_q | digit_bad;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d     = ST_DONE;
            out_value_d = acc_mac;
            out_err_d   = err_q | digit_bad;
          end
        end
      end
      ST_DONE: begin
        if (out_fire) begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
          out_value_d = '0;
          out_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
    end
  end

  // Result registers are cleared outside DONE, so out_value/out_err read 0 while invalid.
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Directed bench for bcd_digit_accumulator (NUM_DIGITS=4, OUT_W=14), both input codings.
module tb_bcd_digit_accumulator;

  localparam int OUT_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bcd_digit_accumulator_if #(.OUT_W(OUT_W)) bus ();

  bcd_digit_accumulator #(
    .NUM_DIGITS (4),
    .OUT_W      (OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef BCD_ACC_EXCESS3_IN_EN
  localparam logic [3:0] BAD = 4'hD;
  function automatic logic [3:0] enc(input logic [3:0] d);
    return d + 4'd3;
  endfunction
`else
  localparam logic [3:0] BAD = 4'hB;
  function automatic logic [3:0] enc(input logic [3:0] d);
    return d;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_digit(input string tag, input logic [3:0] code);
    bus.in_valid = 1'b1;
    bus.in_digit = code;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ".out_valid_low"}, 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_digit = 4'd0;
  endtask

  task automatic send_word(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
    send_digit(tag, c0);
    send_digit(tag, c1);
    send_digit(tag, c2);
    send_digit(tag, c3);
  endtask

  // Called one cycle after the last digit; drains the result when out_ready is high.
  task automatic expect_result(input string tag, input int value, input logic err);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".in_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, ".out_value"}, 32'(bus.out_value), 32'(value));
    check({tag, ".out_err"}, 32'(bus.out_err), 32'(err));
    $display("word %s: out_value=%0d out_err=%0d", tag, bus.out_value, bus.out_err);
    if (bus.out_ready) begin
      tick();
      check({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".value_zero"}, 32'(bus.out_value), 32'd0);
      check({tag, ".err_zero"}, 32'(bus.out_err), 32'd0);
      check({tag, ".ready_back"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'd0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_value", 32'(bus.out_value), 32'd0);
    check("reset.out_err", 32'(bus.out_err), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);

    send_word("w1234", enc(4'd1), enc(4'd2), enc(4'd3), enc(4'd4));
    expect_result("w1234", 1234, 1'b0);

    send_word("w9999", enc(4'd9), enc(4'd9), enc(4'd9), enc(4'd9));
    expect_result("w9999", 9999, 1'b0);
    send_word("w0007", enc(4'd0), enc(4'd0), enc(4'd0), enc(4'd7));
    expect_result("w0007", 7, 1'b0);

    send_word("w5x21", enc(4'd5), BAD, enc(4'd2), enc(4'd1));
    expect_result("w5x21", 5021, 1'b1);
    send_word("w0001", enc(4'd0), enc(4'd0), enc(4'd0), enc(4'd1));
    expect_result("w0001", 1, 1'b0);

    // Bubbles between digits must not disturb the partial word.
    send_digit("w6059", enc(4'd6));
    tick();
    tick();
    check("bubble.in_ready", 32'(bus.in_ready), 32'd1);
    send_digit("w6059", enc(4'd0));
    tick();
    send_digit("w6059", enc(4'd5));
    send_digit("w6059", enc(4'd9));
    expect_result("w6059", 6059, 1'b0);

    // Backpressure with a digit pending on the input.
    bus.out_ready = 1'b0;
    send_word("w8765", enc(4'd8), enc(4'd7), enc(4'd6), enc(4'd5));
    expect_result("w8765", 8765, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_digit = enc(4'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold.out_valid", 32'(bus.out_valid), 32'd1);
      check("hold.out_value", 32'(bus.out_value), 32'd8765);
      check("hold.in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("release.out_valid", 32'(bus.out_valid), 32'd0);
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    send_digit("w2001", enc(4'd0));
    send_digit("w2001", enc(4'd0));
    send_digit("w2001", enc(4'd1));
    expect_result("w2001", 2001, 1'b0);

    // Reset mid-word discards the partial result.
    send_digit("abort", enc(4'd3));
    send_digit("abort", enc(4'd4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort.out_valid", 32'(bus.out_valid), 32'd0);
      check("abort.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    send_word("w4321", enc(4'd4), enc(4'd3), enc(4'd2), enc(4'd1));
    expect_result("w4321", 4321, 1'b0);

`ifdef BCD_ACC_EXCESS3_IN_EN
    send_word("x1234", 4'h4, 4'h5, 4'h6, 4'h7);
    expect_result("x1234", 1234, 1'b0);
    send_word("x3d33", 4'h3, 4'hD, 4'h3, 4'h3);
    expect_result("x3d33", 0, 1'b1);
    send_word("x0c21", 4'h0, 4'hC, 4'h5, 4'h4);
    expect_result("x0c21", 921, 1'b1);
`else
    send_word("wf00a", 4'hF, 4'd0, 4'd0, 4'hA);
    expect_result("wf00a", 0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
